alu_result_checker: RTL and testbench
=====================================

# alu_result_checker

Hardware scoreboard that consumes predicted TinyALU results and compares them, in order, against the results the TinyALU actually produces. Expected results arrive on a valid/ready push port and are held in a small in-order queue. Each actual result, marked by the DUT's one-cycle done pulse, is checked against the queue head. The block keeps saturating match, mismatch and unexpected-result counters, plus a capture of the last mismatch, for readback by the testbench or a debug bus.

## Interface
Parameters:
- DEPTH, 4, expected-result queue depth; power of two, 2 or more.
- RES_W, 16, result width (TinyALU 8x8 multiply).
- CNT_W, 16, width of each counter.

Ports:
- clk  in  1  single clock; everything is rising-edge.
- reset  in  1  asynchronous, active-high; clears all state.
- exp_valid  in  1  expected result offered.
- exp_ready  out  1  queue can accept; equals !full.
- exp_result  in  RES_W  expected result value.
- act_valid  in  1  one-cycle done pulse from the DUT monitor.
- act_result  in  RES_W  actual DUT result, qualified by act_valid.
- flush  in  1  synchronous queue clear; counters are untouched.
- level  out  clog2(DEPTH)+1  number of queued expected entries.
- match_cnt  out  CNT_W  compares that matched.
- mismatch_cnt  out  CNT_W  compares that mismatched.
- unexpected_cnt  out  CNT_W  actuals that arrived with nothing to compare against.
- mismatch  out  1  one-cycle pulse per mismatch.
- mismatch_exp  out  RES_W  expected value of the last mismatch.
- mismatch_act  out  RES_W  actual value of the last mismatch.
- sticky_err  out  1  set by any mismatch or unexpected actual; cleared only by reset.

## Operation
- Queue is a circular buffer with read pointer, write pointer and a count register. Pointers wrap modulo DEPTH.
- Push: happens when exp_valid && exp_ready.
  - exp_ready is !full only; a pop in the same cycle does not open space.
- Compare: happens on act_valid.
  - **Queue non-empty:** compare act_result with the head entry, then pop.
  - **Queue empty with a simultaneous push:** bypass. Compare against exp_result directly; nothing is stored and level stays 0.
  - **Queue empty with no push:** unexpected. Increment unexpected_cnt, set sticky_err, and perform no compare.
- Equality is a bitwise compare over all RES_W bits.
- Mismatch:
  - increment mismatch_cnt;
  - pulse mismatch;
  - load mismatch_exp and mismatch_act;
  - set sticky_err.
- Match: increment match_cnt.
- Counters saturate at all-ones and never wrap.
- Non-empty queue with push and act_valid together: pop the head and push the new entry; level is unchanged.
- Flush has priority over push and act_valid in the same cycle.
  - Both are ignored, with no counter change.
  - Pointers and level go to 0.
- Reset mid-operation: all queue contents are discarded and every output returns to its reset value.

## Timing
- Reset values:
  - exp_ready = 1;
  - level = 0;
  - all counters = 0;
  - mismatch = 0;
  - mismatch_exp = 0 and mismatch_act = 0;
  - sticky_err = 0.
- Latency, measured from the act_valid edge:
  - Counters, mismatch, the mismatch captures and sticky_err update at the rising edge that samples act_valid.
  - They are visible in the cycle after act_valid, i.e. 1-cycle latency.
- level and exp_ready update at the edge that samples a push, pop or flush.
- mismatch is high for exactly one cycle per mismatching compare. Back-to-back mismatches hold it high on consecutive cycles.
- act_valid is never stalled; the block accepts one compare per cycle sustained.
- Full queue: a push attempt is refused (exp_ready = 0) and exp_result must be held by the producer.

## Test plan
- **Reset and match.** Reset, push 0x0005, then act_valid with 0x0005. Required: match_cnt = 1, mismatch stays low, level returns to 0.
- **Mismatch.** Push 0x00FE, act 0x00FF. Required: mismatch pulses for 1 cycle, mismatch_exp = 0x00FE, mismatch_act = 0x00FF, mismatch_cnt = 1, sticky_err = 1.
- **Full queue.** Push DEPTH values with no actuals. Required: level = 4 and exp_ready = 0; a 5th push is held. Four matching actuals then drain the queue in FIFO order, giving match_cnt = 4.
- **Empty queue.** act 0x1234 with the queue empty and no push. Required: unexpected_cnt = 1, sticky_err = 1. Then push 0x0042 and act 0x0042 in the same cycle. Required: bypass match, match_cnt increments, level stays 0.
- **Flush.** Queue holds 3 entries; assert flush together with act_valid. Required: level = 0 and all counters unchanged.
- **Asynchronous reset and saturation.**
  - Assert reset between clock edges while entries are queued. Required: all outputs are at reset values immediately.
  - Drive 2^CNT_W + 5 matches. Required: match_cnt holds at all-ones.

Source files
------------

// File: rtl/alu_result_checker_if.sv
// Port bundle for the ALU result scoreboard: expected-result push, actual-result
// strobe, flush control and the counter/capture readback.
interface alu_result_checker_if #(
    parameter int DEPTH = 4,
    parameter int RES_W = 16,
    parameter int CNT_W = 16
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic             exp_valid;
    logic             exp_ready;
    logic [RES_W-1:0] exp_result;
    logic             act_valid;
    logic [RES_W-1:0] act_result;
    logic             flush;
    logic [LW-1:0]    level;
    logic [CNT_W-1:0] match_cnt;
    logic [CNT_W-1:0] mismatch_cnt;
    logic [CNT_W-1:0] unexpected_cnt;
    logic             mismatch;
    logic [RES_W-1:0] mismatch_exp;
    logic [RES_W-1:0] mismatch_act;
    logic             sticky_err;

    modport master (
        output exp_valid, exp_result, act_valid, act_result, flush,
        input  exp_ready, level, match_cnt, mismatch_cnt, unexpected_cnt,
               mismatch, mismatch_exp, mismatch_act, sticky_err
    );

    modport slave (
        input  exp_valid, exp_result, act_valid, act_result, flush,
        output exp_ready, level, match_cnt, mismatch_cnt, unexpected_cnt,
               mismatch, mismatch_exp, mismatch_act, sticky_err
    );
endinterface

// File: rtl/alu_result_checker.sv
// In-order scoreboard: queues predicted TinyALU results and checks each actual
// result against the queue head, keeping saturating counters and a mismatch capture.
module alu_result_checker #(
    parameter int DEPTH = 4,
    parameter int RES_W = 16,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    alu_result_checker_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [RES_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [LW-1:0]    r_count;
    logic [CNT_W-1:0] r_match_cnt;
    logic [CNT_W-1:0] r_mismatch_cnt;
    logic [CNT_W-1:0] r_unexpected_cnt;
    logic             r_mismatch;
    logic [RES_W-1:0] r_mismatch_exp;
    logic [RES_W-1:0] r_mismatch_act;
    logic             r_sticky_err;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_bypass;
    logic             w_unexp;
    logic             w_store;
    logic             w_cmp_en;
    logic             w_match;
    logic [RES_W-1:0] w_cmp_exp;

    assign w_full   = (r_count == LW'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_push   = bus.exp_valid && !w_full && !bus.flush;
    assign w_pop    = bus.act_valid && !w_empty && !bus.flush;
    // An empty queue lets a same-cycle push feed the compare directly without storing it.
    assign w_bypass = bus.act_valid && w_empty && bus.exp_valid && !bus.flush;
    assign w_unexp  = bus.act_valid && w_empty && !bus.exp_valid && !bus.flush;
    assign w_store  = w_push && !w_bypass;
    assign w_cmp_en = w_pop || w_bypass;
    assign w_cmp_exp = w_empty ? bus.exp_result : r_mem[r_rd_ptr];
    assign w_match  = (w_cmp_exp == bus.act_result);

    always_ff @(posedge clk) begin
        if (w_store) r_mem[r_wr_ptr] <= bus.exp_result;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (bus.flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_store) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)   r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_store && !w_pop)      r_count <= r_count + LW'(1);
            else if (w_pop && !w_store) r_count <= r_count - LW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_match_cnt      <= '0;
            r_mismatch_cnt   <= '0;
            r_unexpected_cnt <= '0;
            r_mismatch       <= 1'b0;
            r_mismatch_exp   <= '0;
            r_mismatch_act   <= '0;
            r_sticky_err     <= 1'b0;
        end else begin
            r_mismatch <= 1'b0;
            if (w_cmp_en && w_match) begin
                if (r_match_cnt != '1) r_match_cnt <= r_match_cnt + CNT_W'(1);
            end
            if (w_cmp_en && !w_match) begin
                if (r_mismatch_cnt != '1) r_mismatch_cnt <= r_mismatch_cnt + CNT_W'(1);
                r_mismatch     <= 1'b1;
                r_mismatch_exp <= w_cmp_exp;
                r_mismatch_act <= bus.act_result;
                r_sticky_err   <= 1'b1;
            end
            if (w_unexp) begin
                if (r_unexpected_cnt != '1) r_unexpected_cnt <= r_unexpected_cnt + CNT_W'(1);
                r_sticky_err <= 1'b1;
            end
        end
    end

    assign bus.exp_ready      = !w_full;
    assign bus.level          = r_count;
    assign bus.match_cnt      = r_match_cnt;
    assign bus.mismatch_cnt   = r_mismatch_cnt;
    assign bus.unexpected_cnt = r_unexpected_cnt;
    assign bus.mismatch       = r_mismatch;
    assign bus.mismatch_exp   = r_mismatch_exp;
    assign bus.mismatch_act   = r_mismatch_act;
    assign bus.sticky_err     = r_sticky_err;
endmodule

// File: tb/tb_alu_result_checker.sv
// Directed bench for alu_result_checker: a queue-based reference model checked every
// cycle, plus hand-computed literal expectations at each scenario boundary.
module tb_alu_result_checker;
    localparam int DEPTH = 4;
    localparam int RES_W = 16;
    localparam int CNT_W = 16;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    alu_result_checker_if #(.DEPTH(DEPTH), .RES_W(RES_W), .CNT_W(CNT_W)) u_if ();

    alu_result_checker #(.DEPTH(DEPTH), .RES_W(RES_W), .CNT_W(CNT_W)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] required);
        n_tests++;
        if (actual !== required) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, required, $time);
        end
    endtask

    // Reference model: a plain queue of expected values and integer counters.
    int         m_q[$];
    int         m_match    = 0;
    int         m_mis      = 0;
    int         m_unexp    = 0;
    logic       m_mismatch = 1'b0;
    logic [15:0] m_mexp    = '0;
    logic [15:0] m_mact    = '0;
    logic       m_sticky   = 1'b0;

    always @(posedge clk or posedge reset) begin : model
        int  e;
        bit  has_exp;
        bit  do_push;
        if (reset) begin
            m_q.delete();
            m_match    <= 0;
            m_mis      <= 0;
            m_unexp    <= 0;
            m_mismatch <= 1'b0;
            m_mexp     <= '0;
            m_mact     <= '0;
            m_sticky   <= 1'b0;
        end else begin
            m_mismatch <= 1'b0;
            has_exp = 1'b0;
            e       = 0;
            do_push = u_if.exp_valid && (m_q.size() < DEPTH);
            if (u_if.flush) begin
                m_q.delete();
            end else begin
                if (u_if.act_valid) begin
                    if (m_q.size() > 0) begin
                        e = m_q.pop_front();
                        has_exp = 1'b1;
                    end else if (u_if.exp_valid) begin
                        e = int'(u_if.exp_result);
                        has_exp = 1'b1;
                        do_push = 1'b0;
                    end else begin
                        m_unexp  <= (m_unexp == MAXC) ? MAXC : m_unexp + 1;
                        m_sticky <= 1'b1;
                    end
                    if (has_exp) begin
                        if (e == int'(u_if.act_result)) begin
                            m_match <= (m_match == MAXC) ? MAXC : m_match + 1;
                        end else begin
                            m_mis      <= (m_mis == MAXC) ? MAXC : m_mis + 1;
                            m_mismatch <= 1'b1;
                            m_mexp     <= e[15:0];
                            m_mact     <= u_if.act_result;
                            m_sticky   <= 1'b1;
                        end
                    end
                end
                if (do_push) m_q.push_back(int'(u_if.exp_result));
            end
        end
    end

    always @(negedge clk) begin
        chk("level",          32'(u_if.level),          32'(m_q.size()));
        chk("exp_ready",      32'(u_if.exp_ready),      32'(m_q.size() < DEPTH));
        chk("match_cnt",      32'(u_if.match_cnt),      32'(m_match));
        chk("mismatch_cnt",   32'(u_if.mismatch_cnt),   32'(m_mis));
        chk("unexpected_cnt", 32'(u_if.unexpected_cnt), 32'(m_unexp));
        chk("mismatch",       32'(u_if.mismatch),       32'(m_mismatch));
        chk("mismatch_exp",   32'(u_if.mismatch_exp),   32'(m_mexp));
        chk("mismatch_act",   32'(u_if.mismatch_act),   32'(m_mact));
        chk("sticky_err",     32'(u_if.sticky_err),     32'(m_sticky));
    end

    // Inputs are applied 1 ns after an edge, held for one cycle, then returned to idle.
    task automatic step(input logic ev, input logic [15:0] er, input logic av,
                        input logic [15:0] ar, input logic fl);
        u_if.exp_valid  = ev;
        u_if.exp_result = er;
        u_if.act_valid  = av;
        u_if.act_result = ar;
        u_if.flush      = fl;
        @(posedge clk);
        #1;
        u_if.exp_valid  = 1'b0;
        u_if.act_valid  = 1'b0;
        u_if.flush      = 1'b0;
    endtask

    task automatic push(input logic [15:0] v);
        step(1'b1, v, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic act(input logic [15:0] v);
        step(1'b0, 16'h0, 1'b1, v, 1'b0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"},  32'(u_if.exp_ready),      32'd1);
        chk({tag, "_level"},  32'(u_if.level),          32'd0);
        chk({tag, "_match"},  32'(u_if.match_cnt),      32'd0);
        chk({tag, "_mis"},    32'(u_if.mismatch_cnt),   32'd0);
        chk({tag, "_unexp"},  32'(u_if.unexpected_cnt), 32'd0);
        chk({tag, "_pulse"},  32'(u_if.mismatch),       32'd0);
        chk({tag, "_mexp"},   32'(u_if.mismatch_exp),   32'd0);
        chk({tag, "_mact"},   32'(u_if.mismatch_act),   32'd0);
        chk({tag, "_sticky"}, 32'(u_if.sticky_err),     32'd0);
    endtask

    initial begin
        u_if.exp_valid  = 1'b0;
        u_if.exp_result = '0;
        u_if.act_valid  = 1'b0;
        u_if.act_result = '0;
        u_if.flush      = 1'b0;
        #1 reset = 1'b1;
        #2;
        chk_reset_vals("rst0");
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        @(posedge clk);
        #1;

        // Reset and match
        push(16'h0005);
        chk("t1_level_after_push", 32'(u_if.level), 32'd1);
        act(16'h0005);
        chk("t1_match", 32'(u_if.match_cnt), 32'd1);
        chk("t1_no_pulse", 32'(u_if.mismatch), 32'd0);
        chk("t1_level", 32'(u_if.level), 32'd0);

        // Single mismatch
        push(16'h00FE);
        act(16'h00FF);
        chk("t2_pulse", 32'(u_if.mismatch), 32'd1);
        chk("t2_mexp", 32'(u_if.mismatch_exp), 32'h00FE);
        chk("t2_mact", 32'(u_if.mismatch_act), 32'h00FF);
        chk("t2_miscnt", 32'(u_if.mismatch_cnt), 32'd1);
        chk("t2_sticky", 32'(u_if.sticky_err), 32'd1);
        step(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
        chk("t2_pulse_end", 32'(u_if.mismatch), 32'd0);

        // Back-to-back mismatches
        push(16'h0030);
        push(16'h0031);
        act(16'h0000);
        chk("b2b_pulse1", 32'(u_if.mismatch), 32'd1);
        act(16'h0001);
        chk("b2b_pulse2", 32'(u_if.mismatch), 32'd1);
        chk("b2b_mexp", 32'(u_if.mismatch_exp), 32'h0031);
        chk("b2b_mact", 32'(u_if.mismatch_act), 32'h0001);
        chk("b2b_miscnt", 32'(u_if.mismatch_cnt), 32'd3);

        // Push and pop in the same cycle on a non-empty queue
        push(16'h0020);
        step(1'b1, 16'h0021, 1'b1, 16'h0020, 1'b0);
        chk("ovl_level", 32'(u_if.level), 32'd1);
        chk("ovl_match", 32'(u_if.match_cnt), 32'd2);
        act(16'h0021);
        chk("ovl_match2", 32'(u_if.match_cnt), 32'd3);

        // Full queue
        for (int i = 1; i <= DEPTH; i++) push(16'(i));
        chk("t3_level_full", 32'(u_if.level), 32'd4);
        chk("t3_ready_low", 32'(u_if.exp_ready), 32'd0);
        push(16'h0005);
        chk("t3_refused_level", 32'(u_if.level), 32'd4);
        for (int i = 1; i <= DEPTH; i++) act(16'(i));
        chk("t3_match", 32'(u_if.match_cnt), 32'd7);
        chk("t3_level_empty", 32'(u_if.level), 32'd0);
        chk("t3_miscnt", 32'(u_if.mismatch_cnt), 32'd3);

        // Empty queue: unexpected, then bypass
        act(16'h1234);
        chk("t4_unexp", 32'(u_if.unexpected_cnt), 32'd1);
        chk("t4_sticky", 32'(u_if.sticky_err), 32'd1);
        step(1'b1, 16'h0042, 1'b1, 16'h0042, 1'b0);
        chk("t4_bypass_match", 32'(u_if.match_cnt), 32'd8);
        chk("t4_bypass_level", 32'(u_if.level), 32'd0);

        // Flush wins over push and act_valid
        push(16'h0010);
        push(16'h0011);
        push(16'h0012);
        chk("t5_level3", 32'(u_if.level), 32'd3);
        step(1'b1, 16'h0013, 1'b1, 16'h0010, 1'b1);
        chk("t5_level0", 32'(u_if.level), 32'd0);
        chk("t5_match", 32'(u_if.match_cnt), 32'd8);
        chk("t5_mis", 32'(u_if.mismatch_cnt), 32'd3);
        chk("t5_unexp", 32'(u_if.unexpected_cnt), 32'd1);
        act(16'h0010);
        chk("t5_post_flush_unexp", 32'(u_if.unexpected_cnt), 32'd2);

        // Asynchronous reset between edges with entries queued
        push(16'h0007);
        push(16'h0008);
        #2 reset = 1'b1;
        #1;
        chk_reset_vals("t6_async");
        @(negedge clk);
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        act(16'h0007);
        chk("t6_discarded", 32'(u_if.unexpected_cnt), 32'd1);
        chk("t6_match0", 32'(u_if.match_cnt), 32'd0);

        // Match counter saturation via sustained bypass compares
        u_if.exp_valid  = 1'b1;
        u_if.exp_result = 16'h00AA;
        u_if.act_valid  = 1'b1;
        u_if.act_result = 16'h00AA;
        repeat ((1 << CNT_W) + 5) @(posedge clk);
        #1;
        u_if.exp_valid = 1'b0;
        u_if.act_valid = 1'b0;
        chk("t6_sat", 32'(u_if.match_cnt), 32'hFFFF);
        chk("t6_sat_level", 32'(u_if.level), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("t6_sat_hold", 32'(u_if.match_cnt), 32'hFFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
